// File: rtl/updown_cascade_stage.sv
// updown_cascade_stage: mod-(MAX+1) up/down digit counting upstream carry/borrow pulses.
// Define UPDOWN_CASCADE_SAT_EN to saturate at the ends and lock instead of wrapping.
module updown_cascade_stage #(
   parameter int WIDTH = 4,
   parameter int MAX   = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dir,
   input  logic             cin,
   input  logic             hold,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             cout,
   output logic             ovf,
   output logic             unf,
   output logic             paused
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
`ifdef UPDOWN_CASCADE_SAT_EN
   typedef enum logic [1:0] {RUN, PAUSE, LOCK} state_t;
`else
   typedef enum logic {RUN, PAUSE} state_t;
`endif
   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             step, wrap;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= RUN;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   always_comb begin
      step    = (state_q == RUN) & ~hold & ~clr & cin;
      wrap    = step & (dir ? (count_q == '0) : (count_q == MAX_V));
      state_d = state_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (clr) begin
         state_d = RUN;
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else if (state_q == RUN) begin
         if (hold)
            state_d = PAUSE;
         else if (cin) begin
            ovf_d = ovf_q | (wrap & ~dir);
            unf_d = unf_q | (wrap & dir);
`ifdef UPDOWN_CASCADE_SAT_EN
            state_d = wrap ? LOCK : RUN;
            count_d = wrap ? count_q : (dir ? count_q - 1'b1 : count_q + 1'b1);
`else
            count_d = wrap ? (dir ? MAX_V : '0) : (dir ? count_q - 1'b1 : count_q + 1'b1);
`endif
         end
      end else if (state_q == PAUSE)
         state_d = hold ? PAUSE : RUN;
   end
   assign count  = count_q;
   assign cout   = wrap;
   assign ovf    = ovf_q;
   assign unf    = unf_q;
   assign paused = (state_q == PAUSE);
endmodule
